// File: rtl/cpu_pkg.sv
// Shared fetch-path types: controller states, default parameters and the
// instruction bundle handed from fetch to decode.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] DEF_ERR_WORD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  function automatic logic misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_reg.sv
// Fetch output register with valid/ready hold.
// Ports: clk, rst_n, load/flush/ready controls, din bundle; valid, dout.
module fetch_stage_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  logic   ready,
  input  if_id_t din,
  output logic   valid,
  output if_id_t dout
);

  // flush beats load beats drain; otherwise hold (stall keeps data)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/HALT FSM, pc, redirect, error halt.
// Ports: clk, rst_n, start, imem_*, redir_*, if_* handshake, halted, err_pc.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] ERR_WORD = DEF_ERR_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted,
  output logic [31:0] err_pc
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  err_n;
  logic         free, in_run, bad_word;
  logic         load, flush;
  if_id_t       din, dout;

  assign free     = !if_valid || if_ready;
  assign in_run   = (state == RUN);
  assign bad_word = (imem_rdata == ERR_WORD);
  assign flush    = in_run && redir_valid;
  assign load     = in_run && !redir_valid && free && !bad_word;

  assign din.instr = imem_rdata;
  assign din.pc    = pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    err_n   = err_pc;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          pc_n    = RESET_PC;
        end
      end
      RUN: begin
        if (redir_valid) begin
          pc_n = redir_pc;
          if (misaligned(redir_pc)) begin
            state_n = HALT;
            err_n   = redir_pc;
          end
        end else if (free) begin
          // an error word halts at the faulting pc, nothing delivered
          if (bad_word) begin
            state_n = HALT;
            err_n   = pc;
          end else begin
            pc_n = pc + 32'd4;
          end
        end
      end
      HALT: begin
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      err_pc <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      err_pc <= err_n;
    end
  end

  fetch_stage_reg u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .flush (flush),
    .ready (if_ready),
    .din   (din),
    .valid (if_valid),
    .dout  (dout)
  );

  assign imem_addr = pc;
  assign if_instr  = dout.instr;
  assign if_pc     = dout.pc;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic [31:0] err_pc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h3e80_2403;
    if (a == 32'h0040_0004) return 32'h3ec0_2483;
    if (a[6:2] == 5'h0A) return ERRW;
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .halted      (halted),
    .err_pc      (err_pc)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got %h want %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; redir_valid = 0; redir_pc = '0; if_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_in();
    step();
    rst_n = 1;
  endtask

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [31:0] ead;
    logic        eh;
    logic [31:0] eer;
  } vec_t;

  vec_t vt[16];

  // behavioural model state
  logic        m_run, m_halt, m_v;
  logic [31:0] m_pc, m_ipc, m_ins, m_err;

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_v = 0;
    m_pc = RPC; m_ipc = 0; m_ins = 0; m_err = 0;
  endtask

  // one clock of the controller's rules, given the inputs now applied
  task automatic model_step();
    logic [31:0] w;
    if (!rst_n) begin
      model_reset();
    end else if (m_halt) begin
      if (if_ready) m_v = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1;
        m_pc = RPC;
      end
    end else if (redir_valid) begin
      m_v = 0;
      m_pc = redir_pc;
      if (redir_pc % 4 != 0) begin
        m_run = 0; m_halt = 1; m_err = redir_pc;
      end
    end else if (!m_v || if_ready) begin
      w = mem_word(m_pc);
      if (w == ERRW) begin
        m_v = 0;
        m_run = 0; m_halt = 1; m_err = m_pc;
      end else begin
        m_v = 1; m_ins = w; m_ipc = m_pc;
        m_pc = m_pc + 4;
      end
    end
  endtask

  initial begin
    logic        ok;
    logic [31:0] a;
    int          k;

    rst_n = 1;
    idle_in();
    #2;
    rst_n = 0;
    #1;
    chk("rst_valid", {31'b0, if_valid}, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_err", err_pc, 0);
    step();
    rst_n = 1;

    vt[0]  = '{1, 0, 0, 1, 0, 0, 0, 32'h00400000, 0, 0};
    vt[1]  = '{0, 0, 0, 1, 1, 32'h00400000, 32'h3e802403,
               32'h00400004, 0, 0};
    vt[2]  = '{0, 0, 0, 1, 1, 32'h00400004, 32'h3ec02483,
               32'h00400008, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 1, 32'h00400004, 32'h3ec02483,
               32'h00400008, 0, 0};
    vt[4]  = vt[3];
    vt[5]  = vt[3];
    vt[6]  = '{0, 0, 0, 1, 1, 32'h00400008, 32'hFFF70008,
               32'h0040000C, 0, 0};
    vt[7]  = '{0, 1, 32'h00400018, 0, 0, 0, 0, 32'h00400018, 0, 0};
    vt[8]  = '{0, 0, 0, 1, 1, 32'h00400018, 32'hFFE70018,
               32'h0040001C, 0, 0};
    vt[9]  = '{0, 0, 0, 1, 1, 32'h0040001C, 32'hFFE3001C,
               32'h00400020, 0, 0};
    vt[10] = '{0, 0, 0, 1, 1, 32'h00400020, 32'hFFDF0020,
               32'h00400024, 0, 0};
    vt[11] = '{0, 0, 0, 1, 1, 32'h00400024, 32'hFFDB0024,
               32'h00400028, 0, 0};
    vt[12] = '{0, 0, 0, 0, 1, 32'h00400024, 32'hFFDB0024,
               32'h00400028, 0, 0};
    vt[13] = vt[12];
    vt[14] = '{0, 0, 0, 1, 0, 0, 0, 32'h00400028, 1, 32'h00400028};
    vt[15] = '{1, 1, 32'h00400000, 1, 0, 0, 0,
               32'h00400028, 1, 32'h00400028};

    for (int i = 0; i < 16; i++) begin
      start = vt[i].st;
      redir_valid = vt[i].rv;
      redir_pc = vt[i].rpc;
      if_ready = vt[i].rdy;
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vt[i].ev});
      chk($sformatf("v%0d_addr", i), imem_addr, vt[i].ead);
      chk($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, vt[i].eh});
      chk($sformatf("v%0d_err", i), err_pc, vt[i].eer);
      if (vt[i].ev) begin
        chk($sformatf("v%0d_pc", i), if_pc, vt[i].epc);
        chk($sformatf("v%0d_instr", i), if_instr, vt[i].ein);
      end
    end

    // reset mid-RUN with a held instruction
    do_reset();
    start = 1; step();
    start = 0; if_ready = 0; step();
    chk("mr_valid_before", {31'b0, if_valid}, 1);
    rst_n = 0;
    #1;
    chk("mr_valid", {31'b0, if_valid}, 0);
    chk("mr_instr", if_instr, 0);
    chk("mr_pc", if_pc, 0);
    chk("mr_addr", imem_addr, RPC);
    chk("mr_halted", {31'b0, halted}, 0);
    step();
    rst_n = 1;
    if_ready = 1;
    step(); step();
    chk("mr_nostart_valid", {31'b0, if_valid}, 0);
    chk("mr_nostart_addr", imem_addr, RPC);

    // redirect ignored in IDLE
    redir_valid = 1; redir_pc = 32'h00400100;
    step();
    chk("idle_redir_addr", imem_addr, RPC);
    redir_valid = 0;

    // misaligned redirect halts
    start = 1; step();
    start = 0; redir_valid = 1; redir_pc = 32'h00400002;
    step();
    chk("mis_halted", {31'b0, halted}, 1);
    chk("mis_err", err_pc, 32'h00400002);
    chk("mis_valid", {31'b0, if_valid}, 0);

    // pc wraps modulo 2^32
    do_reset();
    start = 1; step();
    start = 0; redir_valid = 1; redir_pc = 32'hFFFFFFFC; if_ready = 1;
    step();
    chk("wrap_addr0", imem_addr, 32'hFFFFFFFC);
    redir_valid = 0;
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_halted", {31'b0, halted}, 0);
    chk("wrap_pc", if_pc, 32'hFFFFFFFC);
    chk("wrap_instr", if_instr, 32'h0003FFFC);

    // randomized traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n = !(($urandom_range(63) == 0) ||
                (m_halt && $urandom_range(7) == 0));
      start = ($urandom_range(3) == 0);
      if_ready = ($urandom_range(2) != 0);
      redir_valid = ($urandom_range(9) == 0);
      k = $urandom_range(7);
      a = $urandom;
      if (k == 0) redir_pc = a | 32'h1;
      else if (k == 1) redir_pc = {29'h1FFFFFFF, a[0], 2'b00};
      else redir_pc = RPC + {a[7:0], 2'b00};
      model_step();
      step();
      ok = (if_valid === m_v) && (halted === m_halt) &&
           (err_pc === m_err) && (imem_addr === m_pc);
      if (m_v) ok = ok && (if_pc === m_ipc) && (if_instr === m_ins);
      total++;
      if (ok) passed++;
      else $display("FAIL rand%0d got v%b h%b e%h a%h p%h i%h want v%b h%b e%h a%h p%h i%h",
                    c, if_valid, halted, err_pc, imem_addr, if_pc, if_instr,
                    m_v, m_halt, m_err, m_pc, m_ipc, m_ins);
      rst_n = 1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000, first fetch address after reset.
REQ-002 SHALL have parameter ERR_WORD, default 32'hDEADBEEF, word the instruction memory returns for an unmapped address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; leaves IDLE.
REQ-006 SHALL have port imem_addr  output  32  address to the combinational instruction memory.
REQ-007 SHALL have port imem_rdata  input  32  instruction word for imem_addr, valid in the same cycle.
REQ-008 SHALL have port redir_valid  input  1  redirect request (branch/jump) this cycle.
REQ-009 SHALL have port redir_pc  input  32  redirect target.
REQ-010 SHALL have port if_valid  output  1  if_instr/if_pc hold a fetched instruction.
REQ-011 SHALL have port if_ready  input  1  decode accepts the instruction this cycle.
REQ-012 SHALL have port if_instr  output  32  fetched instruction word.
REQ-013 SHALL have port if_pc  output  32  address of if_instr.
REQ-014 SHALL have port halted  output  1  controller is in HALT.
REQ-015 SHALL have port err_pc  output  32  address that caused HALT; 0 otherwise.

Function
REQ-016 SHALL implement states IDLE, RUN, HALT; reset state IDLE.
REQ-017 IDLE: no fetch; on start=1 go to RUN with pc = RESET_PC.
REQ-018 imem_addr SHALL equal pc in every state.
REQ-019 RUN: a fetch occurs in a cycle when the output register is free (if_valid=0 or if_ready=1) and redir_valid=0.
REQ-020 On a fetch with imem_rdata != ERR_WORD: next cycle if_valid=1, if_instr=imem_rdata, if_pc=pc; pc += 4; latency one cycle from address to if_valid.
REQ-021 If if_valid=1 and if_ready=0, if_instr/if_pc/pc SHALL hold unchanged (no fetch, no loss).
REQ-022 If if_ready=1 with no fetch in the same cycle, if_valid SHALL clear next cycle.
REQ-023 redir_valid=1 in RUN SHALL have priority over fetch and stall: next cycle pc = redir_pc and if_valid=0 (flush), regardless of if_ready.
REQ-024 A redirect with redir_pc[1:0] != 0 SHALL go to HALT with err_pc = redir_pc.
REQ-025 On a fetch with imem_rdata == ERR_WORD: go to HALT, err_pc = pc, no instruction delivered; a pending if_valid=1 SHALL remain until accepted.
REQ-026 pc increment SHALL be modulo 2^32 (32'hFFFFFFFC + 4 = 0), not an error.
REQ-027 HALT: no fetch, redirects and start ignored, halted=1; exit only by reset.
REQ-028 redir_valid and start in IDLE SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, err_pc=0.
REQ-030 Reset asserted mid-RUN or mid-HALT SHALL discard any held instruction; first fetch after release requires a new start.

Structure
REQ-031 State enum (IDLE/RUN/HALT), RESET_PC and ERR_WORD defaults SHALL live in shared package cpu_pkg.
REQ-032 Output register with valid/ready hold SHALL be a sub-module named fetch_stage_reg; state machine and pc logic stay in fetch_ctrl.

Verification
REQ-033 Reset, start, if_ready=1, memory returning 3e802403/3ec02483 -> if_pc 00400000 then 00400004 on consecutive cycles, if_instr matching.
REQ-034 if_ready=0 for 3 cycles with if_valid=1 at if_pc 00400004 -> if_pc/if_instr stable, imem_addr stays 00400008; release -> 00400008 next.
REQ-035 redir_valid=1, redir_pc=00400018 while if_valid=1, if_ready=0 -> next cycle if_valid=0, imem_addr=00400018; following cycle if_pc=00400018.
REQ-036 Fetch at 00400028 returns DEADBEEF -> halted=1, err_pc=00400028, no if_valid for that address; start ignored afterwards.
REQ-037 redir_pc=00400002 -> halted=1, err_pc=00400002; redirect to FFFFFFFC then fetch -> next imem_addr=00000000, halted=0.
REQ-038 rst_n low mid-RUN with if_valid=1 -> all outputs zero immediately, state IDLE, imem_addr=00400000.
